// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with whole-scan debounce.
// Define KEYPAD_RELEASE_EVENT_EN to build the key_release_o pulse.
module keypad_scanner #(
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       clk_en_i,
  input  logic [3:0] row_i,
  output logic [3:0] col_o,
  output logic [3:0] key_code_o,
  output logic       key_valid_o,
  output logic       key_held_o,
  output logic       key_release_o
);

  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_SCANS);

  typedef enum logic {IDLE, PRESSED} state_t;

  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n, nxt;
  logic [3:0] cand, cand_n, code_n;
  logic valid_n, held_n;
  logic [3:0] row_s1, row_s2, pr;
  logic [1:0] acc_n, rcnt, base_n, sum_n;
  logic [3:0] acc_code, base_code, scan_code;
  logic [1:0] ridx, cidx;
  logic [2:0] s;
  logic last;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      row_s1 <= 4'b1111;
      row_s2 <= 4'b1111;
    end else begin
      row_s1 <= row_i;
      row_s2 <= row_s1;
    end
  end

  always_comb begin
    pr = ~row_s2;
    rcnt = 2'd1;
    ridx = 2'd0;
    case (pr)
      4'b0000: rcnt = 2'd0;
      4'b0001: ridx = 2'd0;
      4'b0010: ridx = 2'd1;
      4'b0100: ridx = 2'd2;
      4'b1000: ridx = 2'd3;
      default: rcnt = 2'd2;
    endcase
    case (col_o)
      4'b1101: cidx = 2'd1;
      4'b1011: cidx = 2'd2;
      4'b0111: cidx = 2'd3;
      default: cidx = 2'd0;
    endcase
    // Column 0 starts a fresh scan, so ignore stale accumulators
    base_n = (cidx == 2'd0) ? 2'd0 : acc_n;
    base_code = (cidx == 2'd0) ? 4'd0 : acc_code;
    s = {1'b0, base_n} + {1'b0, rcnt};
    sum_n = (s >= 3'd2) ? 2'd2 : s[1:0];
    scan_code = (rcnt == 2'd1) ? {ridx, cidx} : base_code;
    last = (cidx == 2'd3);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      col_o <= 4'b1110;
      acc_n <= 2'd0;
      acc_code <= 4'd0;
    end else if (clk_en_i) begin
      col_o <= {col_o[2:0], col_o[3]};
      acc_n <= sum_n;
      acc_code <= scan_code;
    end
  end

`ifdef KEYPAD_RELEASE_EVENT_EN
  logic rel_n;
`endif

  always_comb begin
    state_n = state;
    cnt_n = cnt;
    cand_n = cand;
    code_n = key_code_o;
    valid_n = 1'b0;
    held_n = key_held_o;
    nxt = '0;
`ifdef KEYPAD_RELEASE_EVENT_EN
    rel_n = 1'b0;
`endif
    if (clk_en_i && last) begin
      case (state)
        IDLE: begin
          if (sum_n == 2'd1) begin
            if (scan_code == cand) begin
              nxt = (cnt == CMAX) ? cnt : cnt + 1'b1;
            end else begin
              cand_n = scan_code;
              nxt = CW'(1);
            end
          end
          cnt_n = nxt;
          if (nxt == CMAX) begin
            code_n = cand_n;
            valid_n = 1'b1;
            held_n = 1'b1;
            cnt_n = '0;
            state_n = PRESSED;
          end
        end
        default: begin
          if (sum_n == 2'd0)
            nxt = (cnt == CMAX) ? cnt : cnt + 1'b1;
          cnt_n = nxt;
          if (nxt == CMAX) begin
            held_n = 1'b0;
`ifdef KEYPAD_RELEASE_EVENT_EN
            rel_n = 1'b1;
`endif
            cnt_n = '0;
            state_n = IDLE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state <= IDLE;
      cnt <= '0;
      cand <= 4'd0;
      key_code_o <= 4'd0;
      key_valid_o <= 1'b0;
      key_held_o <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      cand <= cand_n;
      key_code_o <= code_n;
      key_valid_o <= valid_n;
      key_held_o <= held_n;
    end
  end

`ifdef KEYPAD_RELEASE_EVENT_EN
  logic rel_q;
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) rel_q <= 1'b0;
    else rel_q <= rel_n;
  end
  assign key_release_o = rel_q;
`else
  assign key_release_o = 1'b0;
`endif

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Scans a 4x4 matrix keypad on a Pmod header and reports debounced key presses as a 4-bit key code with a one-cycle valid strobe. It is the input-side counterpart of the seven-segment display path. It drives one active-low column at a time from a ring pattern advanced by the shared scan-rate enable, samples the row lines, and debounces across whole scans. Its outputs feed the logic that assembles the 16-bit value shown on the display.

## Interface
- DEBOUNCE_SCANS, default 4: number of consecutive complete scans with identical key status needed to accept a press or a release. Legal range is 1..15.
- clk_i  input  1: system clock. One clock domain only.
- reset_i  input  1: asynchronous, active-high reset.
- clk_en_i  input  1: scan tick, one clk_i cycle wide. Consecutive ticks are at least 4 clk_i cycles apart.
- row_i  input  4: keypad rows. Active-low, pulled up externally, asynchronous to clk_i.
- col_o  output  4: keypad column drive. Exactly one bit is low at any time.
- key_code_o  output  4: code of the last accepted key, equal to row_index*4 + col_index.
- key_valid_o  output  1: one-cycle pulse when a press is accepted.
- key_held_o  output  1: high from press acceptance until release acceptance.
- key_release_o  output  1: one-cycle pulse when a release is accepted. Tied 0 unless the macro is defined (see Configuration).

## Operation
- row_i passes through a 2-flop synchronizer clocked every cycle, not gated by clk_en_i. Both stages reset to 4'b1111.
- Column rotation:
  - col_o resets to 4'b1110 (column 0).
  - On each clk_en_i it rotates left: 1110 -> 1101 -> 1011 -> 0111 -> 1110.
- Sampling: on each clk_en_i, before rotating, the synchronized rows are sampled for the column currently driven. A low row bit means key (row, col) is pressed.
- Scan completion: a scan is complete at the clk_en_i that samples column 3. At that point the scan is classified:
  - NONE: zero keys pressed.
  - SINGLE(code): exactly one key pressed.
  - MULTI: two or more keys pressed.
- Scan accumulators reset at the start of each scan.
- State machine, two states:
  - IDLE:
    - A SINGLE(code) equal to the previous scan's candidate increments the debounce counter.
    - A SINGLE(code) with a different code loads the new candidate and sets the counter to 1.
    - NONE or MULTI clears the counter.
    - When the counter reaches DEBOUNCE_SCANS: key_code_o <= candidate, pulse key_valid_o, set key_held_o, clear the counter, go to PRESSED.
  - PRESSED:
    - A NONE scan increments the counter. Any SINGLE or MULTI scan clears it. There is no roll-over: other keys never generate events while in PRESSED.
    - When the counter reaches DEBOUNCE_SCANS: clear key_held_o, pulse key_release_o (macro only), clear the counter, go to IDLE.
- Counter width is $clog2(DEBOUNCE_SCANS+1). The counter saturates and never wraps.
- key_code_o holds its value across release and changes only on an acceptance.
- DEBOUNCE_SCANS=1 accepts on the first qualifying scan.

## Timing
- Reset values: col_o=4'b1110, key_code_o=0, key_valid_o=0, key_held_o=0, key_release_o=0, state IDLE, counter 0, candidate 0.
- Asserting reset_i acts immediately and asynchronously. No pulses are emitted on or after reset. Scanning restarts at column 0 on the first clk_en_i after reset deasserts.
- Row settle budget: col_o changes in the cycle after clk_en_i. The synchronizer adds 2 cycles, which is why ticks must be at least 4 cycles apart.
- Output timing:
  - key_valid_o, key_release_o, key_held_o and key_code_o are registered.
  - They update in the clk_i cycle immediately after the column-3 clk_en_i of the deciding scan.
  - Pulses are high for exactly one clk_i cycle.
- Press latency: DEBOUNCE_SCANS complete scans, i.e. 4*DEBOUNCE_SCANS ticks, plus 1 cycle after the last sample.
- clk_en_i low: all state frozen, outputs held, pulses not repeated.

## Configuration
- KEYPAD_RELEASE_EVENT_EN:
  - Defined: key_release_o pulses for one cycle on release acceptance, with the same timing as key_held_o falling.
  - Undefined: key_release_o is constant 0 and the release-pulse register is not built. key_held_o behaviour is identical in both builds.

## Test plan
- Reset check: assert reset_i mid-scan -> outputs take reset values within the same cycle. After release, col_o sequence on ticks is 1110, 1101, 1011, 0111, 1110.
- Clean press: DEBOUNCE_SCANS=4, tick period 8, hold row 2 low while column 1 is driven -> exactly one key_valid_o pulse at the end of scan 4, key_code_o=9, key_held_o=1.
- Bounce: key 9 present for scans 1-3, absent for scan 4, present for scans 5-8 -> no pulse until the end of scan 8, then a single pulse.
- Multi-key: keys 9 and 14 pressed for 6 scans -> no pulse. Release 14 -> pulse with key_code_o=9 after 4 further scans.
- Release: after accepting key 9, release for 4 scans:
  - With the macro: key_held_o falls and key_release_o pulses once. key_code_o stays 9.
  - Without the macro: key_release_o stays 0 throughout.
- Reset while held: key 9 held with key_held_o=1, pulse reset_i -> key_held_o=0 and no release pulse. With the key still pressed, a fresh pulse occurs after 4 scans.
